// File: rtl/t05_instr_queue_if.sv
// rtl/t05_instr_queue_if.sv - fetch/decode handshake bundle for the instruction queue
// master = fetch/decode side driving the queue, slave = the queue itself.
interface t05_instr_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_instr;
    logic [WIDTH-1:0] fetch_adr;
    logic             fetch_ready;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_instr;
    logic [WIDTH-1:0] dec_adr;
    logic             dec_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output flush, fetch_valid, fetch_instr, fetch_adr, dec_ready,
        input  fetch_ready, dec_valid, dec_instr, dec_adr, count, full, empty
    );

    modport slave (
        input  flush, fetch_valid, fetch_instr, fetch_adr, dec_ready,
        output fetch_ready, dec_valid, dec_instr, dec_adr, count, full, empty
    );
endinterface

// File: rtl/t05_instr_queue.sv
// rtl/t05_instr_queue.sv - fetch-to-decode instruction queue with flush
// Optional same-cycle empty-queue bypass enabled by defining T05_IQ_BYPASS_EN.
module t05_instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    t05_instr_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_mem [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_dec_valid;
    logic [WIDTH-1:0]   w_dec_instr;
    logic [WIDTH-1:0]   w_dec_adr;
    logic [2*WIDTH-1:0] w_head_entry;

    assign w_full       = (r_count == CNT_MAX);
    assign w_empty      = (r_count == '0);
    assign w_head_entry = r_mem[r_head];

`ifdef T05_IQ_BYPASS_EN
    logic w_bypass;

    // Empty queue forwards the fetch word straight to decode; it is only
    // stored if decode does not take it this cycle.
    assign w_bypass    = w_empty && !q.flush && q.fetch_valid;
    assign w_dec_valid = (!w_empty && !q.flush) || w_bypass;
    assign w_pop       = !w_empty && !q.flush && q.dec_ready;
    assign w_push      = q.fetch_valid && !w_full && !q.flush
                         && !(w_bypass && q.dec_ready);

    always_comb begin
        w_dec_instr = '0;
        w_dec_adr   = '0;
        if (w_bypass) begin
            w_dec_instr = q.fetch_instr;
            w_dec_adr   = q.fetch_adr;
        end else if (w_dec_valid) begin
            w_dec_instr = w_head_entry[2*WIDTH-1:WIDTH];
            w_dec_adr   = w_head_entry[WIDTH-1:0];
        end
    end
`else
    assign w_dec_valid = !w_empty && !q.flush;
    assign w_pop       = w_dec_valid && q.dec_ready;
    assign w_push      = q.fetch_valid && !w_full && !q.flush;

    always_comb begin
        w_dec_instr = '0;
        w_dec_adr   = '0;
        if (w_dec_valid) begin
            w_dec_instr = w_head_entry[2*WIDTH-1:WIDTH];
            w_dec_adr   = w_head_entry[WIDTH-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never reset; the output mux masks it whenever empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_tail] <= {q.fetch_instr, q.fetch_adr};
        end
    end

    assign q.fetch_ready = !w_full;
    assign q.dec_valid   = w_dec_valid;
    assign q.dec_instr   = w_dec_instr;
    assign q.dec_adr     = w_dec_adr;
    assign q.count       = r_count;
    assign q.full        = w_full;
    assign q.empty       = w_empty;
endmodule

// File: tb/tb_t05_instr_queue.sv
// tb/tb_t05_instr_queue.sv - self-checking bench for t05_instr_queue
// Checks every cycle against a queue-based model, plus literal scenario expectations.
module tb_t05_instr_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
`ifdef T05_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] adr;
    } ent_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    ent_t mq[$];

    logic        t_rst, t_flush, t_fv, t_dr;
    logic [31:0] t_ins, t_adr;

    t05_instr_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) qif ();

    t05_instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_model();
        int          sz;
        logic        e_valid;
        logic [31:0] e_ins, e_adr;
        sz      = mq.size();
        e_valid = (sz > 0 && !t_flush) || (BYP && sz == 0 && !t_flush && t_fv);
        e_ins   = 32'h0;
        e_adr   = 32'h0;
        if (e_valid) begin
            if (sz > 0) begin
                e_ins = mq[0].ins;
                e_adr = mq[0].adr;
            end else begin
                e_ins = t_ins;
                e_adr = t_adr;
            end
        end
        chk("model_count", 32'(qif.count), 32'(sz));
        chk("model_full", 32'(qif.full), 32'(sz == DEPTH));
        chk("model_empty", 32'(qif.empty), 32'(sz == 0));
        chk("model_fetch_ready", 32'(qif.fetch_ready), 32'(sz < DEPTH));
        chk("model_dec_valid", 32'(qif.dec_valid), 32'(e_valid));
        chk("model_dec_instr", qif.dec_instr, e_ins);
        chk("model_dec_adr", qif.dec_adr, e_adr);
    endtask

    task automatic model_update();
        int sz;
        bit take_bypass;
        bit do_pop;
        bit do_push;
        if (t_rst || t_flush) begin
            mq.delete();
        end else begin
            sz          = mq.size();
            take_bypass = BYP && sz == 0 && t_fv && t_dr;
            do_pop      = sz > 0 && t_dr;
            do_push     = t_fv && sz < DEPTH && !take_bypass;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{ins: t_ins, adr: t_adr});
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic fv,
                         input logic [31:0] ins, input logic [31:0] adr, input logic dr);
        @(negedge clk);
        t_rst = r; t_flush = f; t_fv = fv; t_ins = ins; t_adr = adr; t_dr = dr;
        rst             = r;
        qif.flush       = f;
        qif.fetch_valid = fv;
        qif.fetch_instr = ins;
        qif.fetch_adr   = adr;
        qif.dec_ready   = dr;
        #1;
        if (!r) compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input logic r, input logic f, input logic fv,
                       input logic [31:0] ins, input logic [31:0] adr, input logic dr);
        drive(r, f, fv, ins, adr, dr);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 32'(qif.count), 32'd0);
        chk({tag, "_empty"}, 32'(qif.empty), 32'd1);
        chk({tag, "_full"}, 32'(qif.full), 32'd0);
        chk({tag, "_fetch_ready"}, 32'(qif.fetch_ready), 32'd1);
        chk({tag, "_dec_valid"}, 32'(qif.dec_valid), 32'd0);
        chk({tag, "_dec_instr"}, qif.dec_instr, 32'd0);
        chk({tag, "_dec_adr"}, qif.dec_adr, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();
        check_reset_values("reset");
        tick();

        // Two pushes, decoder stalled
        cyc(1'b0, 1'b0, 1'b1, 32'h00000013, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h00100093, 32'h4, 1'b0);
        idle();
        chk("two_push_count", 32'(qif.count), 32'd2);
        chk("two_push_instr", qif.dec_instr, 32'h00000013);
        chk("two_push_adr", qif.dec_adr, 32'h0);
        tick();

        // Fill, then offer a 5th word while popping
        cyc(1'b0, 1'b0, 1'b1, 32'h00200113, 32'h8, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h00300193, 32'hC, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h00500293, 32'h10, 1'b1);
        chk("full_flag", 32'(qif.full), 32'd1);
        chk("full_fetch_ready", 32'(qif.fetch_ready), 32'd0);
        tick();
        idle();
        chk("full_pop_count", 32'(qif.count), 32'd3);
        chk("full_pop_head", qif.dec_instr, 32'h00100093);
        tick();

        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1);
            chk("stream_count", 32'(qif.count), 32'd3);
            tick();
        end
        idle();
        chk("stream_head", qif.dec_instr, 32'h1007);
        tick();

        // Flush with push and pop requested
        drive(1'b0, 1'b1, 1'b1, 32'hCAFE0001, 32'h200, 1'b1);
        chk("flush_cycle_dec_valid", 32'(qif.dec_valid), 32'd0);
        tick();
        idle();
        chk("flush_count", 32'(qif.count), 32'd0);
        chk("flush_empty", 32'(qif.empty), 32'd1);
        chk("flush_dec_valid", 32'(qif.dec_valid), 32'd0);
        tick();

        // Reset mid-operation with a push
        cyc(1'b0, 1'b0, 1'b1, 32'hA1, 32'h20, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'hA2, 32'h24, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hA3, 32'h28, 1'b1);
        idle();
        check_reset_values("mid_reset");
        tick();

        // Empty-queue fetch consumed immediately
        drive(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h300, 1'b1);
        chk("byp_dec_valid", 32'(qif.dec_valid), BYP ? 32'd1 : 32'd0);
        chk("byp_dec_instr", qif.dec_instr, BYP ? 32'hDEADBEEF : 32'd0);
        tick();
        idle();
        chk("byp_count_after", 32'(qif.count), BYP ? 32'd0 : 32'd1);
        chk("byp_next_valid", 32'(qif.dec_valid), BYP ? 32'd0 : 32'd1);
        tick();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), $urandom, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 1) == 1);
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/t05_instr_queue.md
T05_INSTR_QUEUE -- requirements
Module: t05_instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter WIDTH, default 32, instruction and address width in bits.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  branch/jump redirect; discards all queued and in-flight entries.
REQ-006 fetch_valid  input  1  fetch stage presents a completed instruction this cycle.
REQ-007 fetch_instr  input  WIDTH  instruction word from the fetch stage.
REQ-008 fetch_adr  input  WIDTH  address the instruction was fetched from.
REQ-009 fetch_ready  output  1  queue can accept a push this cycle.
REQ-010 dec_valid  output  1  head entry is valid for the decoder / control unit.
REQ-011 dec_instr  output  WIDTH  head instruction word.
REQ-012 dec_adr  output  WIDTH  head instruction address.
REQ-013 dec_ready  input  1  decoder consumes the head this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 full, empty  output  1 each  occupancy == DEPTH, occupancy == 0.

Function
REQ-016 Push SHALL occur on a rising edge when fetch_valid && fetch_ready && !flush; the entry is written at the tail and the tail pointer advances.
REQ-017 Pop SHALL occur on a rising edge when dec_valid && dec_ready && !flush; the head pointer advances.
REQ-018 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-019 count SHALL increment on push-only, decrement on pop-only, and be unchanged on simultaneous push and pop.
REQ-020 fetch_ready SHALL equal !full, registered-state only; no combinational path from dec_ready to fetch_ready.
REQ-021 When full, fetch_valid SHALL be ignored even if a pop occurs in the same cycle; the data is not stored.
REQ-022 dec_valid SHALL equal !empty && !flush; dec_instr/dec_adr SHALL show the head entry when dec_valid, else 0.
REQ-023 Entries SHALL leave in push order; contents are never modified after write.
REQ-024 Without bypass, minimum latency is 1 cycle: push at edge N gives dec_valid high after edge N.
REQ-025 Flush SHALL, at the next edge, zero head, tail and count; any push or pop in the flush cycle is discarded.
REQ-026 dec_ready while dec_valid is low SHALL have no effect; count never underflows or exceeds DEPTH.

Reset
REQ-027 With rst high at a rising edge: head=0, tail=0, count=0, so empty=1, full=0, fetch_ready=1, dec_valid=0, dec_instr=0, dec_adr=0.
REQ-028 rst SHALL override flush, push and pop in the same cycle; reset mid-operation discards all entries.
REQ-029 Storage array contents need not be reset; no output may expose them while empty.

Configuration
REQ-030 Macro T05_IQ_BYPASS_EN: when defined and the queue is empty and not flushing, dec_valid SHALL follow fetch_valid combinationally, with dec_instr/dec_adr = fetch_instr/fetch_adr.
REQ-031 With T05_IQ_BYPASS_EN, if bypassed data is consumed (dec_ready high) the entry SHALL NOT be stored and count stays 0; if not consumed it is pushed normally.
REQ-032 Without T05_IQ_BYPASS_EN, REQ-022 and REQ-024 apply unchanged and no input-to-dec_* combinational path exists.

Verification
REQ-033 Reset, then push 0x00000013 @0x0, 0x00100093 @0x4 with dec_ready=0 -> count=2, dec_instr=0x00000013, dec_adr=0x0.
REQ-034 DEPTH=4, fill with 4 pushes, hold fetch_valid with dec_ready=1 for one cycle -> full=1, fetch_ready=0, 5th word not stored, count=3 afterwards.
REQ-035 Continuous push+pop for 10 cycles -> count constant, outputs in order, pointers wrap past 3 without data loss.
REQ-036 Count=3, assert flush with fetch_valid=1 and dec_ready=1 -> next cycle count=0, empty=1, dec_valid=0, no pop recorded.
REQ-037 Queue holding 2 entries, assert rst with push -> next cycle all outputs at reset values.
REQ-038 Bypass build, empty queue, fetch_valid=1, fetch_instr=0xDEADBEEF, dec_ready=1 -> same-cycle dec_valid=1, dec_instr=0xDEADBEEF, count stays 0; non-bypass build -> dec_valid only next cycle.
